// File: rtl/tick_sched.sv
// Timer scheduler: one shared prescaler produces clock-enable ticks that
// advance NCH periodic/one-shot channel counters behind a small register window.
module tick_sched #(
  parameter int NCH = 4,
  parameter int DW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr,
  input  logic [2:0]     addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata,
  output logic           tick,
  output logic [NCH-1:0] fire,
  output logic           irq
);

  localparam logic [DW:0] ONE = {{DW{1'b0}}, 1'b1};

  logic [DW-1:0]  shadow;
  logic [DW-1:0]  div_a;
  logic [DW-1:0]  pcnt;
  logic [NCH-1:0] en;
  logic [NCH-1:0] oneshot;
  logic [NCH-1:0] pend;
  logic [DW-1:0]  period [NCH];
  logic [DW-1:0]  ccnt   [NCH];

  logic           running;
  logic [DW:0]    div_eff;
  logic [DW:0]    pcnt_inc;
  logic [DW:0]    per_eff  [NCH];
  logic [DW:0]    ccnt_inc [NCH];
  logic [NCH-1:0] expire;
  logic           wr_pre;
  logic           wr_ctrl;
  logic           wr_pend;
  logic [NCH-1:0] wr_per;
  logic [NCH-1:0] pend_clr;

  // Increments are one bit wider than the counters so all-ones never wraps.
  always_comb begin
    running  = |en;
    div_eff  = (div_a == '0) ? ONE : {1'b0, div_a};
    pcnt_inc = {1'b0, pcnt} + ONE;
    tick     = running && (pcnt_inc >= div_eff);
  end

  always_comb begin
    expire = '0;
    for (int i = 0; i < NCH; i++) begin
      per_eff[i]  = (period[i] == '0) ? ONE : {1'b0, period[i]};
      ccnt_inc[i] = {1'b0, ccnt[i]} + ONE;
      expire[i]   = tick && en[i] && (ccnt_inc[i] >= per_eff[i]);
    end
  end

  always_comb begin
    wr_pre   = wr && (addr == 3'd0);
    wr_ctrl  = wr && (addr == 3'd1);
    wr_pend  = wr && (addr == 3'd2);
    pend_clr = wr_pend ? wdata[NCH-1:0] : '0;
    wr_per   = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_per[i] = wr && (addr == 3'(4 + i));
    end
  end

  // The divisor only changes on a tick (or while idle), so a tick interval is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      div_a  <= '0;
      pcnt   <= '0;
    end else begin
      if (wr_pre) begin
        shadow <= wdata;
      end
      if (!running || tick) begin
        pcnt  <= '0;
        div_a <= shadow;
      end else begin
        pcnt <= pcnt_inc[DW-1:0];
      end
    end
  end

  // A CTRL write overrides a one-shot self-clear; hardware pending set beats software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= '0;
      oneshot <= '0;
      pend    <= '0;
      fire    <= '0;
      for (int i = 0; i < NCH; i++) begin
        period[i] <= '0;
        ccnt[i]   <= '0;
      end
    end else begin
      fire <= expire;
      pend <= (pend & ~pend_clr) | expire;
      if (wr_ctrl) begin
        en      <= wdata[NCH-1:0];
        oneshot <= wdata[NCH+3:4];
      end else begin
        en <= en & ~(expire & oneshot);
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_per[i]) begin
          period[i] <= wdata;
        end
        if (!en[i] || expire[i]) begin
          ccnt[i] <= '0;
        end else if (tick) begin
          ccnt[i] <= ccnt_inc[i][DW-1:0];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: rdata = shadow;
      3'd1: begin
        rdata[NCH-1:0]   = en;
        rdata[NCH+3:4]   = oneshot;
      end
      3'd2: rdata[NCH-1:0] = pend;
      3'd3: rdata = '0;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (addr == 3'(4 + i)) begin
            rdata = period[i];
          end
        end
      end
    endcase
  end

  assign irq = |pend;

endmodule

// File: tb/tb_tick_sched.sv
// Directed self-checking bench for tick_sched; inputs change and outputs are
// sampled on the falling clock edge, register writes land on the next rising edge.
module tb_tick_sched;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        tick;
  logic [3:0]  fire;
  logic        irq;

  int compared   = 0;
  int mismatched = 0;
  int early_ticks;

  tick_sched #(.NCH(4), .DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tick  (tick),
    .fire  (fire),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus write, issued on a falling edge and committed on the following rising edge.
  task automatic applyStimulus(input logic [2:0] a, input logic [15:0] d);
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    addr  = 3'd0;
    wdata = '0;

    // Reset state
    #2;
    checkOutput("rst tick", tick, 0);
    checkOutput("rst fire", fire, 0);
    checkOutput("rst irq", irq, 0);
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      checkOutput($sformatf("rst rdata a%0d", a), rdata, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Periodic: PRESCALE=3, PERIOD0=2, expiries every 6 cycles, pending cleared at E9
    applyStimulus(3'd0, 16'd3);
    applyStimulus(3'd4, 16'd2);
    applyStimulus(3'd1, 16'h0001);
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("per tick c%0d", k), tick, (k % 3 == 2) ? 1 : 0);
      checkOutput($sformatf("per fire c%0d", k), fire, (k == 6 || k == 12 || k == 18) ? 1 : 0);
      checkOutput($sformatf("per irq c%0d", k), irq, ((k >= 6 && k <= 8) || k >= 12) ? 1 : 0);
      if (k == 8) begin
        wr = 1'b1; addr = 3'd2; wdata = 16'h0001;
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
    end
    applyStimulus(3'd1, 16'h0000);
    applyStimulus(3'd2, 16'h000F);
    checkOutput("per idle tick", tick, 0);
    checkOutput("per idle irq", irq, 0);

    // One-shot: PERIOD1=4, PRESCALE=1, single fire1 at E4, enable1 self-clears
    applyStimulus(3'd5, 16'd4);
    applyStimulus(3'd0, 16'd1);
    applyStimulus(3'd1, 16'h0022);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("os tick c%0d", k), tick, (k < 4) ? 1 : 0);
      checkOutput($sformatf("os fire c%0d", k), fire, (k == 4) ? 4'b0010 : 4'b0000);
      checkOutput($sformatf("os ctrl c%0d", k), rdata, (k < 4) ? 16'h0022 : 16'h0020);
      @(negedge clk);
    end
    addr = 3'd2;
    #1;
    checkOutput("os pending", rdata, 16'h0002);
    @(negedge clk);
    applyStimulus(3'd2, 16'h000F);

    // Shadow prescale: interval 4, write 2 mid-period, then write 5 on a tick edge
    applyStimulus(3'd4, 16'd100);
    applyStimulus(3'd0, 16'd4);
    applyStimulus(3'd1, 16'h0001);
    for (int k = 0; k < 27; k++) begin
      checkOutput($sformatf("shd tick c%0d", k), tick,
                  (k == 3 || k == 7 || k == 9 || k == 11 || k == 13 ||
                   k == 15 || k == 20 || k == 25) ? 1 : 0);
      if (k == 4) begin
        wr = 1'b1; addr = 3'd0; wdata = 16'd2;
      end else if (k == 13) begin
        wr = 1'b1; addr = 3'd0; wdata = 16'd5;
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("shd prescale read", rdata, 16'd5);
    applyStimulus(3'd1, 16'h0000);

    // PRESCALE=0, PERIOD0=0: fire every cycle; pending set beats clear at E4
    applyStimulus(3'd0, 16'd0);
    applyStimulus(3'd4, 16'd0);
    applyStimulus(3'd1, 16'h0001);
    for (int k = 0; k < 7; k++) begin
      checkOutput($sformatf("zero tick c%0d", k), tick, 1);
      checkOutput($sformatf("zero fire c%0d", k), fire, (k >= 1) ? 1 : 0);
      checkOutput($sformatf("zero irq c%0d", k), irq, (k >= 1) ? 1 : 0);
      if (k >= 4) begin
        checkOutput($sformatf("setclr pend c%0d", k), rdata, 16'h0001);
      end
      if (k == 3) begin
        wr = 1'b1; addr = 3'd2; wdata = 16'h0001;
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
    end
    applyStimulus(3'd1, 16'h0000);
    applyStimulus(3'd2, 16'h0001);
    checkOutput("zero off fire", fire, 0);
    checkOutput("zero off irq", irq, 0);

    // CTRL rewrite on a one-shot expiry edge keeps the channel alive for one more period
    applyStimulus(3'd5, 16'd2);
    applyStimulus(3'd1, 16'h0022);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("coll tick c%0d", k), tick, (k <= 3) ? 1 : 0);
      checkOutput($sformatf("coll fire c%0d", k), fire, (k == 2 || k == 4) ? 4'b0010 : 4'b0000);
      if (k == 1) begin
        wr = 1'b1; addr = 3'd1; wdata = 16'h0022;
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("coll ctrl", rdata, 16'h0020);
    applyStimulus(3'd2, 16'h000F);

    // PERIOD lowered below the running count expires on the next tick
    applyStimulus(3'd0, 16'd2);
    applyStimulus(3'd4, 16'd10);
    applyStimulus(3'd1, 16'h0001);
    for (int k = 0; k < 14; k++) begin
      checkOutput($sformatf("low tick c%0d", k), tick, (k % 2 == 1) ? 1 : 0);
      checkOutput($sformatf("low fire c%0d", k), fire, (k == 8 || k == 12) ? 1 : 0);
      if (k == 6) begin
        wr = 1'b1; addr = 3'd4; wdata = 16'd2;
      end else begin
        wr = 1'b0;
      end
      @(negedge clk);
    end
    applyStimulus(3'd1, 16'h0000);
    applyStimulus(3'd2, 16'h000F);

    // PRESCALE all-ones: first tick after 65535 cycles, no early wrap
    applyStimulus(3'd0, 16'hFFFF);
    applyStimulus(3'd4, 16'd1);
    applyStimulus(3'd1, 16'h0001);
    early_ticks = 0;
    for (int k = 0; k < 65536; k++) begin
      if (k < 65534) begin
        if (tick) early_ticks++;
      end else if (k == 65534) begin
        checkOutput("max early ticks", early_ticks, 0);
        checkOutput("max tick", tick, 1);
        checkOutput("max fire pre", fire, 0);
      end else begin
        checkOutput("max tick post", tick, 0);
        checkOutput("max fire", fire, 1);
      end
      @(negedge clk);
    end
    checkOutput("max irq", irq, 1);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst tick", tick, 0);
    checkOutput("arst fire", fire, 0);
    checkOutput("arst irq", irq, 0);
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      checkOutput($sformatf("arst rdata a%0d", a), rdata, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 3'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post rst tick c%0d", k), tick, 0);
      checkOutput($sformatf("post rst ctrl c%0d", k), rdata, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tick_sched.md
# tick_sched

Timer scheduler that shares one programmable prescaler among NCH periodic/one-shot channels. It turns the free-running divide-by-N function into single-cycle clock-enable ticks instead of a divided clock. It sits on the CPU peripheral bus behind a small register window and raises an interrupt when any channel expires. Prescale changes are committed only at a prescaler boundary, so reconfiguration never produces a short or long tick.

## Interface
- NCH, 4: number of channels, 1..4.
- DW, 16: data width of registers, prescaler and channel counters.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr  input  1  write strobe; one write per asserted cycle.
- addr  input  3  register address.
- wdata  input  DW  write data.
- rdata  output  DW  combinational read data for addr.
- tick  output  1  prescaler tick, one clk wide.
- fire  output  NCH  per-channel expiry pulse, one clk wide, registered.
- irq  output  1  OR of pending bits.

## Operation
- Register map:
  - 0 PRESCALE: write loads the shadow; read returns the shadow.
  - 1 CTRL: bits[NCH-1:0] enable, bits[NCH+3:4] oneshot.
  - 2 PENDING: read returns pending bits; writing 1 clears the bit, writing 0 has no effect.
  - 3: reserved, reads 0, writes ignored.
  - 4+i PERIOD[i]: read/write; addresses for i >= NCH read 0 and ignore writes.
  - Unused CTRL bits read 0.
- Running = OR of enable bits. When not running, the prescaler count is held at 0 and the active divisor is reloaded from the shadow every cycle.
- Prescaler:
  - Active divisor div_a; an effective divisor of 0 is treated as 1.
  - tick = running and (pcnt+1 >= div_a), combinational.
  - On a tick edge: pcnt <= 0 and div_a <= shadow. Otherwise pcnt <= pcnt+1.
  - Increment is computed DW+1 bits wide, so there is no wrap at all-ones.
- Channel i, effective period = PERIOD[i], with 0 treated as 1:
  - While enable[i]=0: ccnt[i] held at 0.
  - A 0->1 enable transition resets ccnt[i] to 0.
  - On an edge with tick=1 and enable[i]=1: if ccnt[i]+1 >= period, then ccnt[i] <= 0, pending[i] <= 1 and fire[i] high next cycle. If oneshot[i], enable[i] <= 0 on the same edge. Otherwise ccnt[i] <= ccnt[i]+1.
  - A PERIOD write while running takes effect immediately. If ccnt >= new period-1, the channel expires on the next tick.
- Simultaneous events:
  - Hardware pending set and software clear of the same bit on one edge: set wins.
  - CTRL write on the same edge as a one-shot self-clear: the written value wins. The expiry (pending, fire) still occurs.
  - PRESCALE write on a tick edge: div_a takes the old shadow; the new value commits at the next tick.
- Reset values:
  - All registers, counters, pending, div_a and shadow are 0.
  - tick, fire and irq are 0; rdata follows the reset register values.
  - Assertion mid-operation aborts all counts immediately; no fire is emitted.

## Timing
- Register write at edge E: visible on rdata from E onward; enable counting starts with pcnt=0 after E.
- Channel period in clk cycles = div_eff * period_eff.
- Example: PRESCALE=3, PERIOD0=2, CTRL enable0 written at E0:
  - tick high in cycles following E2 and E5.
  - Expiry at E6: pending0=1, fire0 high E6..E7, irq high from E6.
- irq falls the cycle after a PENDING write clears the last set bit.
- div=1 (or 0): tick is continuously high while running; period 1 channels fire every cycle.

## Test plan
- Reset: drive rst_n low mid-count with ch0 active -> all outputs 0 asynchronously, rdata 0 at every address; after release, no tick until re-enabled.
- Periodic: PRESCALE=3, PERIOD0=2, enable0 -> fire0 pulses at E6, E12, E18; irq set at E6; PENDING write 1 clears it, bit set again at E12.
- One-shot: PERIOD1=4, PRESCALE=1, enable1+oneshot1 -> single fire1 at E4; CTRL reads enable1=0 from E4; no further tick.
- Shadow prescale: running at PRESCALE=4, write 2 mid-period -> current tick interval stays 4, subsequent intervals 2; write on a tick edge delays commit by one interval.
- Collisions: set-vs-clear of pending on the same edge -> bit remains 1; CTRL write on a one-shot expiry edge re-enabling -> channel continues, fire still pulses.
- Boundaries: PRESCALE=0, PERIOD=0 -> fire every cycle; PRESCALE=all-ones -> tick every 65535 cycles, no wrap; PERIOD lowered below ccnt -> fire on next tick.
